// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder slice.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_t;

  function automatic int steps(input int n, input int chunk);
    return n / chunk;
  endfunction

endpackage

// File: rtl/serial_adder_adder_n.sv
// Combinational W-bit ripple-carry adder built from single-bit full adders.
module adder1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module adder_n #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);

  // w_carry[i] is the carry into bit i; w_carry[W] leaves the MSB.
  logic [W:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder1 u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (w_carry[i]),
      .sum   (sum[i]),
      .c_out (w_carry[i+1])
    );
  end

  assign c_out = w_carry[W];
  assign c_msb = w_carry[W-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle N-bit adder, CHUNK bits per cycle, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int N     = 32,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  import adder_pkg::*;

  localparam int STEPS = steps(N, CHUNK);
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((N % CHUNK) != 0 || STEPS < 1) begin : g_badCfg
    $error("serial_adder: N must be a non-zero multiple of CHUNK");
  end

  adder_state_t r_state, w_nextState;
  logic [IDXW-1:0] r_idx;
  logic [N-1:0] r_a, r_b, r_sum;
  logic r_carry, r_cOut;
  logic w_accept, w_lastStep;
  int w_base;
  logic [CHUNK-1:0] w_aChunk, w_bChunk, w_chunkSum;
  logic w_chunkCarry;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_cOut;

  assign w_base   = int'(r_idx) * CHUNK;
  assign w_aChunk = r_a[w_base +: CHUNK];
  assign w_bChunk = r_b[w_base +: CHUNK];

`ifdef SERIAL_ADDER_OVF_EN
  logic w_cMsb;
`else
  logic w_unusedMsb;
`endif

  adder_n #(.W(CHUNK)) u_chunkAdder (
    .a     (w_aChunk),
    .b     (w_bChunk),
    .c_in  (r_carry),
    .sum   (w_chunkSum),
    .c_out (w_chunkCarry),
`ifdef SERIAL_ADDER_OVF_EN
    .c_msb (w_cMsb)
`else
    .c_msb (w_unusedMsb)
`endif
  );

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_lastStep  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (r_idx == IDXW'(STEPS - 1)) begin
          w_lastStep  = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured only at acceptance; sum chunks not yet written keep old bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cOut  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= c_in;
        r_idx   <= '0;
      end else if (r_state == BUSY) begin
        r_sum[w_base +: CHUNK] <= w_chunkSum;
        r_carry <= w_chunkCarry;
        r_idx   <= w_lastStep ? '0 : r_idx + IDXW'(1);
        if (w_lastStep) r_cOut <= w_chunkCarry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Overflow is the disagreement between carry into and out of the sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == BUSY && w_lastStep) begin
      r_ovf <= w_cMsb ^ w_chunkCarry;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed table, handshake corner cases, and random ops on
// an 8-bit/2-bit-chunk instance and an 8-bit/single-step instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  logic inValid, inReady, outValid, outReady, cIn, cOut, ovf;
  logic [7:0] opA, opB, sumOut;
  logic inValid1, inReady1, outValid1, outReady1, cIn1, cOut1, ovf1;
  logic [7:0] opA1, opB1, sumOut1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  serial_adder #(.N(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(opA), .b(opB), .c_in(cIn), .out_valid(outValid), .out_ready(outReady),
    .sum(sumOut), .c_out(cOut)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.N(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
    .a(opA1), .b(opB1), .c_in(cIn1), .out_valid(outValid1), .out_ready(outReady1),
    .sum(sumOut1), .c_out(cOut1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // Reference: plain 9-bit addition, overflow from operand/result signs.
  function automatic logic [9:0] refAdd(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    logic ov;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    ov = (x[7] == y[7]) && (full[7] != x[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on the 2-bit-chunk instance, hold the result `hold` cycles, then release.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                               input logic [7:0] es, input logic eco, input logic eov,
                               input int hold);
    int n;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_before_issue", inReady, 1);
    opA = ta; opB = tb; cIn = tc; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    opA = 8'($urandom); opB = 8'($urandom); cIn = 1'($urandom);
    n = 0;
    while (!outValid && n < 12) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, 4);
    checkOutput("sum", sumOut, es);
    checkOutput("c_out", cOut, eco);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ovf", ovf, eov);
`endif
    for (int i = 0; i < hold; i++) begin
      inValid = 1'($urandom);
      opA = 8'($urandom); opB = 8'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", outValid, 1);
      checkOutput("hold_sum", sumOut, es);
      checkOutput("hold_cout", cOut, eco);
      checkOutput("hold_in_ready", inReady, 0);
    end
    inValid = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    inValid = 1'b0;
    checkOutput("release_out_valid", outValid, 0);
    checkOutput("release_idle", inReady, 1);
  endtask

  initial begin
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic rc;
    int n;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1;
    inValid = 0; outReady = 0; opA = 0; opB = 0; cIn = 0;
    inValid1 = 0; outReady1 = 0; opA1 = 0; opB1 = 0; cIn1 = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_sum", sumOut, 0);
    checkOutput("reset_c_out", cOut, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_in_ready", inReady, 0);
    rst = 1'b0;
    #1 checkOutput("post_reset_in_ready", inReady, 1);

    for (int i = 0; i < 7; i++)
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov, 0);

    // Long stall in DONE with noisy inputs.
    applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5);

    // Abort during BUSY, then a normal op.
    @(negedge clk);
    opA = 8'h0F; opB = 8'hF0; cIn = 1'b1; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", outValid, 0);
    checkOutput("abort_sum", sumOut, 0);
    checkOutput("abort_in_ready_rst", inReady, 0);
    rst = 1'b0;
    #1 checkOutput("abort_in_ready", inReady, 1);
    @(negedge clk);
    applyStimulus(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    // in_valid during reset must not be accepted.
    rst = 1'b1;
    inValid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    inValid = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (outValid) n++;
    end
    checkOutput("no_accept_in_reset", n, 0);

    // Random ops with random stall lengths.
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r = refAdd(ra, rb, rc);
      applyStimulus(ra, rb, rc, r[7:0], r[8], r[9], int'($urandom_range(0, 2)));
    end

    // Single-step instance: 1000 random ops, latency 1.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r = refAdd(ra, rb, rc);
      opA1 = ra; opB1 = rb; cIn1 = rc; inValid1 = 1'b1;
      @(negedge clk);
      inValid1 = 1'b0;
      n = 0;
      while (!outValid1 && n < 6) begin
        @(negedge clk);
        n++;
      end
      checkOutput("s1_latency", n, 1);
      checkOutput("s1_sum", sumOut1, r[7:0]);
      checkOutput("s1_c_out", cOut1, r[8]);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("s1_ovf", ovf1, r[9]);
`endif
      outReady1 = 1'b1;
      @(negedge clk);
      outReady1 = 1'b0;
      checkOutput("s1_release", outValid1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
